fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised next-generation instruction fetch stage: owns the program counter, reads a word-addressed instruction memory, and buffers fetched instructions in a FIFO. A valid/ready handshake presents them to decode, so decode back-pressure no longer stalls the PC implicitly. Branch/jump redirects flush the queue. Sits between the top-level processor and `decode`, replacing the single-cycle `fetch`/`PC` pair.

## Interface
- `XLEN`, 32, data and PC width
- `IMEM_WORDS`, 32, instruction memory depth in words (power of 2)
- `FIFO_DEPTH`, 4, queue entries (power of 2, ≥2)
- `RESET_PC`, 0, PC loaded on reset (word aligned)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  fetch enable; low stops new fetches but does not block the queue from draining
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_target`  in  XLEN  new PC; bits [1:0] ignored (forced to 0)
- `imem_we`  in  1  instruction memory write strobe (bench/loader)
- `imem_waddr`  in  $clog2(IMEM_WORDS)  word index written
- `imem_wdata`  in  XLEN  word written
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  decode accepts head entry
- `out_inst`  out  XLEN  instruction at head
- `out_pc`  out  XLEN  PC of head instruction
- `halted`  out  1  self-loop detected, fetching stopped

## Operation
- FSM states:
  - IDLE: entered on `rst`. Moves to FETCH when `en`=1.
  - FETCH: moves back to IDLE when `en`=0. Moves to HALTED when it pushes word 32'h0000006F (`jal x0,0`).
  - HALTED: left only by `redirect_valid` (to FETCH) or `rst`.
- Push condition: state FETCH, not redirecting, and the FIFO is not full or is popping this cycle. The pushed entry is {pc, imem[pc[2 +: log2(IMEM_WORDS)]]}. The same edge sets pc += 4.
- Pop: `out_valid && out_ready`.
- PC wraps modulo 2^XLEN. The imem index uses only the low index bits, so PC beyond depth aliases.
- Redirect: in the same edge, the FIFO empties (count=0, pointers reset), pc <= {target[XLEN-1:2],2'b00}, and HALTED→FETCH (or IDLE if `en`=0). Any push that cycle is discarded. A pop that cycle still counts as accepted.
- The FIFO is a circular buffer with a separate count register of width $clog2(FIFO_DEPTH)+1. It is full at count==FIFO_DEPTH and empty at count==0.
- Simultaneous push and pop when full: both occur, and count stays FIFO_DEPTH.
- Simultaneous push and pop when empty: the popped entry does not exist (out_valid=0), so only the push occurs.
- imem write is applied at the edge. A same-cycle fetch from the same index reads the old word. Contents are undefined until written; reset does not clear imem.

## Timing
- Reset values:
  - `out_valid`=0, `halted`=0, `out_inst`=0, `out_pc`=0.
  - pc=RESET_PC, count=0, state IDLE.
- Fetch latency: `en` high at edge E0 moves to FETCH. The first push happens at E1, and `out_valid`=1 after E1 with `out_pc`=RESET_PC.
- Throughput: one instruction per cycle when `out_ready` is held high.
- Outputs come directly from FIFO head registers, with no combinational path from `out_ready` or `redirect_*` to `out_*`.
- After redirect at edge R: `out_valid`=0 after R. The target instruction is visible after R+1.
- `halted` is asserted after the edge that pushes the self-loop word. It deasserts after the redirect edge.
- Reset mid-stream: all entries are discarded at that edge, and outputs return to reset values.

## Structure
- Shared package `fetch_pkg`:
  - state enum {IDLE, FETCH, HALTED}
  - constant `INST_SELF_LOOP`=32'h0000006F
  - constant `INST_NOP`=32'h00000013
- Sub-module `fetch_fifo` (parametrised width/depth circular buffer, with push/pop/flush, count, full/empty). Instantiated with width 2·XLEN.
- imem storage and the PC/FSM live in `fetch_queue` itself.

## Test plan
- Streaming:
  - Stimulus: load imem[0..3]={13,00500113,00210233,6F}, reset, `en`=1, `out_ready`=1.
  - Response: out_pc 0,4,8,C on consecutive cycles, `halted`=1 after the fourth push, no further pushes.
- Back-pressure:
  - Stimulus: `out_ready`=0 for 10 cycles, FIFO_DEPTH=4.
  - Response: count saturates at 4 and pc=0x10. Release `out_ready` → out_pc 0,4,8,C,10 in order, no loss/duplication.
- Redirect:
  - Stimulus: at pc=0x8 with 2 entries queued, `redirect_valid`=1, target=0x42.
  - Response: out_valid=0 next cycle, then out_pc=0x40.
- Redirect + pop:
  - Stimulus: same cycle with `out_ready`=1.
  - Response: the head is consumed exactly once, and no stale entry appears after the flush.
- Wrap:
  - Stimulus: IMEM_WORDS=32, redirect to 0x7C then 0x80.
  - Response: out_inst equals imem[31] then imem[0], out_pc=0x80.
- Reset mid-operation:
  - Stimulus: `rst` pulse with 3 entries queued and state HALTED.
  - Response: out_valid=0, halted=0, state IDLE, next fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//   state_e        : fetch FSM states
//   INST_SELF_LOOP : encoding of `jal x0,0`; fetching it parks the fetch stage
//   INST_NOP       : encoding of `addi x0,x0,0`
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [31:0] INST_SELF_LOOP = 32'h0000_006F;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO with a separate occupancy counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i (accepted when not full, or when full and popping)
//   pop_i        : drop head entry (ignored when empty)
//   flush_i      : discard all entries; overrides push in the same cycle
//   wdata_i      : entry written on push
//   rdata_o      : head entry, zero when empty
//   count_o      : number of stored entries (0..Depth)
//   full_o       : count_o == Depth
//   empty_o      : count_o == 0
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; emptiness gates the head output instead.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, reads a word-addressed instruction memory and
// buffers {pc, inst} pairs in a FIFO presented to decode over valid/ready.
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : fetch enable (queue keeps draining when low)
//   redirect_valid/_target   : taken branch/jump; flushes queue, reloads PC
//   imem_we/_waddr/_wdata    : instruction memory write port
//   out_valid/out_ready      : head handshake to decode
//   out_inst, out_pc         : head instruction and its PC
//   halted                   : self-loop fetched, fetching parked until redirect/reset
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned    XLEN       = 32,
  parameter int unsigned    IMEM_WORDS = 32,
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_inst,
  output logic [XLEN-1:0]               out_pc,
  output logic                          halted
);

  localparam int unsigned IdxW = $clog2(IMEM_WORDS);

  logic [XLEN-1:0] imem_q [IMEM_WORDS];
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_word;
  state_e          state_q;
  logic            halted_q;
  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic unused_target_lsbs;
  logic unused_fifo_count;
  assign unused_target_lsbs = ^redirect_target[1:0];
  assign unused_fifo_count  = ^fifo_count;

  // Writes land at the edge, so a same-cycle fetch of that index sees the old word.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_waddr] <= imem_wdata;
  end

  // Only the low index bits address memory; higher PCs alias.
  assign fetch_word = imem_q[pc_q[2 +: IdxW]];

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = (state_q == FETCH) && !redirect_valid && (!fifo_full || pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_target[XLEN-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) state_q <= FETCH;
        end
        FETCH: begin
          // Disabling fetch wins over parking on a self-loop pushed the same cycle.
          if (!en) begin
            state_q <= IDLE;
          end else if (push && (fetch_word == XLEN'(INST_SELF_LOOP))) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (redirect_valid) begin
            state_q  <= en ? FETCH : IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted = halted_q;

  fetch_fifo #(
    .Width (2 * XLEN),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({pc_q, fetch_word}),
    .rdata_o ({out_pc, out_inst}),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IW   = 32;
  localparam int unsigned D    = 4;

  logic             clk = 1'b0;
  logic             rst, en, redirect_valid, imem_we, out_ready;
  logic [XLEN-1:0]  redirect_target, imem_wdata;
  logic [4:0]       imem_waddr;
  logic             out_valid, halted;
  logic [XLEN-1:0]  out_inst, out_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN       (XLEN),
    .IMEM_WORDS (IW),
    .FIFO_DEPTH (D),
    .RESET_PC   ('0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_we         (imem_we),
    .imem_waddr      (imem_waddr),
    .imem_wdata      (imem_wdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .halted          (halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: instruction memory, PC, mode (0 idle, 1 fetching, 2 parked), queue.
  logic [31:0] m_mem [IW];
  logic [31:0] m_pc = '0;
  int          m_mode = 0;
  logic [31:0] q_pc [$];
  logic [31:0] q_inst [$];

  task automatic step(input logic r, input logic e, input logic rv, input logic [31:0] rt,
                      input logic rdy, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    bit          took, put;
    logic [31:0] word;
    rst = r; en = e; redirect_valid = rv; redirect_target = rt;
    out_ready = rdy; imem_we = we; imem_waddr = wa; imem_wdata = wd;

    word = m_mem[m_pc[6:2]];
    took = (q_pc.size() != 0) && rdy;
    put  = (m_mode == 1) && !rv && ((q_pc.size() < D) || took);
    if (r) begin
      q_pc.delete(); q_inst.delete();
      m_pc = '0; m_mode = 0;
    end else begin
      if (took) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (rv) begin
        q_pc.delete(); q_inst.delete();
        m_pc = rt & 32'hFFFF_FFFC;
      end else if (put) begin
        q_pc.push_back(m_pc);
        q_inst.push_back(word);
        m_pc = m_pc + 32'd4;
      end
      case (m_mode)
        0: if (e) m_mode = 1;
        1: if (!e) m_mode = 0; else if (put && word == INST_SELF_LOOP) m_mode = 2;
        2: if (rv) m_mode = e ? 1 : 0;
        default: m_mode = 0;
      endcase
    end
    if (we) m_mem[wa] = wd;

    @(posedge clk);
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(q_pc.size() != 0));
    check_eq("out_pc",    64'(out_pc),    64'(q_pc.size() != 0 ? q_pc[0] : 32'h0));
    check_eq("out_inst",  64'(out_inst),  64'(q_inst.size() != 0 ? q_inst[0] : 32'h0));
    check_eq("halted",    64'(halted),    64'(m_mode == 2));
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic e, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, '0, rdy, 1'b0, '0, '0);
  endtask

  task automatic redir(input logic [31:0] t, input logic e, input logic rdy);
    step(1'b0, e, 1'b1, t, rdy, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, a, d);
  endtask

  task automatic reset_pulse();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    out_ready = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    @(negedge clk);
    reset_pulse();
    reset_pulse();
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_pc", 64'(dut.pc_q), 64'(0));

    for (int i = 0; i < int'(IW); i++) wr(5'(i), INST_NOP);
    wr(5'd0, 32'h0000_0013);
    wr(5'd1, 32'h0050_0113);
    wr(5'd2, 32'h0021_0233);
    wr(5'd3, INST_SELF_LOOP);
    wr(5'd31, 32'hDEAD_BEEF);
    reset_pulse();

    // Streaming into a self-loop.
    run(8, 1'b1, 1'b1);
    check_eq("stream_halted", 64'(halted), 64'(1));
    check_eq("stream_pc", 64'(dut.pc_q), 64'h10);

    // Back-pressure: queue saturates, then drains in order.
    wr(5'd3, INST_NOP);
    reset_pulse();
    run(10, 1'b1, 1'b0);
    check_eq("bp_count", 64'(dut.fifo_count), 64'(4));
    check_eq("bp_pc", 64'(dut.pc_q), 64'h10);
    run(8, 1'b1, 1'b1);

    // Redirect with two entries queued.
    reset_pulse();
    run(3, 1'b1, 1'b0);
    check_eq("rd_pc_pre", 64'(dut.pc_q), 64'h8);
    redir(32'h42, 1'b1, 1'b0);
    check_eq("rd_valid", 64'(out_valid), 64'(0));
    run(1, 1'b1, 1'b0);
    check_eq("rd_target_pc", 64'(out_pc), 64'h40);

    // Redirect coinciding with a pop.
    reset_pulse();
    run(3, 1'b1, 1'b0);
    redir(32'h42, 1'b1, 1'b1);
    check_eq("rdpop_valid", 64'(out_valid), 64'(0));
    run(1, 1'b1, 1'b1);
    check_eq("rdpop_pc", 64'(out_pc), 64'h40);
    run(3, 1'b1, 1'b1);

    // Memory index wrap.
    redir(32'h7C, 1'b1, 1'b0);
    run(1, 1'b1, 1'b0);
    check_eq("wrap_inst31", 64'(out_inst), 64'hDEAD_BEEF);
    redir(32'h80, 1'b1, 1'b0);
    run(1, 1'b1, 1'b0);
    check_eq("wrap_inst0", 64'(out_inst), 64'h13);
    check_eq("wrap_pc", 64'(out_pc), 64'h80);

    // Reset while parked with three entries queued.
    wr(5'd2, INST_SELF_LOOP);
    reset_pulse();
    run(5, 1'b1, 1'b0);
    check_eq("mid_halted_pre", 64'(halted), 64'(1));
    check_eq("mid_count_pre", 64'(dut.fifo_count), 64'(3));
    reset_pulse();
    check_eq("mid_valid", 64'(out_valid), 64'(0));
    check_eq("mid_halted", 64'(halted), 64'(0));
    run(2, 1'b1, 1'b0);
    check_eq("mid_refetch_pc", 64'(out_pc), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < int'(IW); i++) begin
      wr(5'(i), ($urandom_range(0, 4) == 0) ? INST_SELF_LOOP : $urandom);
    end
    for (int n = 0; n < 3000; n++) begin
      logic        r, e, rv, rdy, we;
      logic [31:0] rt, wd;
      logic [4:0]  wa;
      r   = ($urandom_range(0, 127) == 0);
      e   = ($urandom_range(0, 7) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       rt = $urandom;
        1:       rt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rt = 32'($urandom_range(0, 255));
      endcase
      rdy = $urandom_range(0, 1) == 1;
      we  = ($urandom_range(0, 9) == 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = ($urandom_range(0, 4) == 0) ? INST_SELF_LOOP : $urandom;
      step(r, e, rv, rt, rdy, we, wa, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
